// File: rtl/net_packet_dispatcher.sv
// Network packet front end: ID filter, packet FIFO and a one-entry dispatch
// register that drives the imem, register-file, PC and barrier-mask write ports.
module net_packet_dispatcher #(
    parameter int unsigned ID_WIDTH        = 10,
    parameter int unsigned ADDR_WIDTH      = 14,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MY_ID           = 0,
    parameter int unsigned IMEM_ADDR_WIDTH = 10,
    parameter int unsigned RD_SIZE         = 5,
    parameter int unsigned MASK_WIDTH      = 3
) (
    input  logic                                            clk,
    input  logic                                            n_reset,
    input  logic                                            pkt_valid_i,
    input  logic [ID_WIDTH+3+6+ADDR_WIDTH+DATA_WIDTH-1:0]   pkt_i,
    output logic                                            pkt_ready_o,
    output logic                                            imem_wen_o,
    input  logic                                            imem_ready_i,
    output logic [IMEM_ADDR_WIDTH-1:0]                      imem_addr_o,
    output logic [15:0]                                     imem_data_o,
    output logic                                            reg_wen_o,
    output logic [RD_SIZE-1:0]                              reg_addr_o,
    output logic [DATA_WIDTH-1:0]                           reg_data_o,
    output logic                                            pc_wen_o,
    output logic [IMEM_ADDR_WIDTH-1:0]                      pc_o,
    output logic                                            bar_wen_o,
    output logic [MASK_WIDTH-1:0]                           bar_mask_o,
    output logic [7:0]                                      drop_count_o,
    output logic                                            op_err_o,
    output logic [$clog2(FIFO_DEPTH):0]                     fifo_count_o
);

    localparam int unsigned PKT_WIDTH = ID_WIDTH + 3 + 6 + ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;
    localparam int unsigned ENT_WIDTH = 3 + ADDR_WIDTH + DATA_WIDTH;

    localparam logic [2:0] OpInstr = 3'd1;
    localparam logic [2:0] OpReg   = 3'd2;
    localparam logic [2:0] OpPc    = 3'd3;
    localparam logic [2:0] OpBar   = 3'd4;

    typedef enum logic [0:0] {DIdle, DIssue} state_e;

    // Packet field decode
    logic [ID_WIDTH-1:0]   w_pkt_id;
    logic [2:0]            w_pkt_op;
    logic [ADDR_WIDTH-1:0] w_pkt_addr;
    logic [DATA_WIDTH-1:0] w_pkt_data;
    logic                  w_id_match;
    logic                  w_op_known;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_bad_op;
    logic                  w_drop;

    assign w_pkt_id   = pkt_i[PKT_WIDTH-1 -: ID_WIDTH];
    assign w_pkt_op   = pkt_i[DATA_WIDTH+ADDR_WIDTH+6 +: 3];
    assign w_pkt_addr = pkt_i[DATA_WIDTH +: ADDR_WIDTH];
    assign w_pkt_data = pkt_i[DATA_WIDTH-1:0];

    assign w_id_match = (w_pkt_id == ID_WIDTH'(MY_ID)) || (w_pkt_id == '1);
    assign w_op_known = (w_pkt_op != 3'd0) && (w_pkt_op <= OpBar);
    assign w_accept   = pkt_valid_i && pkt_ready_o;
    assign w_push     = w_accept && w_id_match && w_op_known;
    assign w_bad_op   = w_accept && w_id_match && (w_pkt_op > OpBar);
    assign w_drop     = w_accept && !w_id_match;

    // Packet FIFO
    logic [ENT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [PTR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_empty;
    logic                 w_pop;

    assign w_empty      = (r_count == '0);
    // No full bypass: a same-cycle pop does not open the door for a push.
    assign pkt_ready_o  = (r_count != CNT_WIDTH'(FIFO_DEPTH));
    assign fifo_count_o = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_pkt_op, w_pkt_addr, w_pkt_data};
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Drop and error accounting
    logic [7:0] r_drop_count;
    logic       r_op_err;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_drop_count <= 8'd0;
            r_op_err     <= 1'b0;
        end else begin
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
            if (w_bad_op) begin
                r_op_err <= 1'b1;
            end
        end
    end

    assign drop_count_o = r_drop_count;
    assign op_err_o     = r_op_err;

    // Dispatch FSM and register
    state_e                r_state;
    state_e                w_state_next;
    logic [2:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_issue_done;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= DIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_issue_done = 1'b0;
        imem_wen_o   = 1'b0;
        reg_wen_o    = 1'b0;
        pc_wen_o     = 1'b0;
        bar_wen_o    = 1'b0;
        case (r_state)
            DIdle: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = DIssue;
                end
            end
            DIssue: begin
                unique case (r_op)
                    OpInstr: imem_wen_o = 1'b1;
                    OpReg:   reg_wen_o  = 1'b1;
                    OpPc:    pc_wen_o   = 1'b1;
                    OpBar:   bar_wen_o  = 1'b1;
                    default: ;
                endcase
                // Only imem writes can stall; everything else retires in one cycle.
                w_issue_done = (r_op != OpInstr) || imem_ready_i;
                if (w_issue_done) begin
                    w_pop        = !w_empty;
                    w_state_next = w_empty ? DIdle : DIssue;
                end
            end
            default: w_state_next = DIdle;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_op   <= 3'd0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_pop) begin
            {r_op, r_addr, r_data} <= r_mem[r_rd_ptr];
        end
    end

    assign imem_addr_o = r_addr[IMEM_ADDR_WIDTH-1:0];
    assign imem_data_o = r_data[15:0];
    assign reg_addr_o  = r_addr[RD_SIZE-1:0];
    assign reg_data_o  = r_data;
    assign pc_o        = r_data[IMEM_ADDR_WIDTH-1:0];
    assign bar_mask_o  = r_data[MASK_WIDTH-1:0];

    // Reserved bits and upper address bits are intentionally ignored.
    logic w_unused;
    assign w_unused = ^{pkt_i[DATA_WIDTH+ADDR_WIDTH +: 6], r_addr};

endmodule

// File: tb/tb_net_packet_dispatcher.sv
// Randomised and directed bench for net_packet_dispatcher, checked against a
// queue-based model of the filter and in-order dispatch rules.
module tb_net_packet_dispatcher;

    localparam int ID_W   = 10;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int PKT_W  = ID_W + 3 + 6 + ADDR_W + DATA_W;

    logic              clk;
    logic              n_reset;
    logic              pkt_valid_i;
    logic [PKT_W-1:0]  pkt_i;
    logic              pkt_ready_o;
    logic              imem_wen_o;
    logic              imem_ready_i;
    logic [9:0]        imem_addr_o;
    logic [15:0]       imem_data_o;
    logic              reg_wen_o;
    logic [4:0]        reg_addr_o;
    logic [31:0]       reg_data_o;
    logic              pc_wen_o;
    logic [9:0]        pc_o;
    logic              bar_wen_o;
    logic [2:0]        bar_mask_o;
    logic [7:0]        drop_count_o;
    logic              op_err_o;
    logic [2:0]        fifo_count_o;

    net_packet_dispatcher #(
        .ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W), .FIFO_DEPTH(DEPTH),
        .MY_ID(0), .IMEM_ADDR_WIDTH(10), .RD_SIZE(5), .MASK_WIDTH(3)
    ) dut (
        .clk(clk), .n_reset(n_reset), .pkt_valid_i(pkt_valid_i), .pkt_i(pkt_i),
        .pkt_ready_o(pkt_ready_o), .imem_wen_o(imem_wen_o), .imem_ready_i(imem_ready_i),
        .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o), .reg_wen_o(reg_wen_o),
        .reg_addr_o(reg_addr_o), .reg_data_o(reg_data_o), .pc_wen_o(pc_wen_o), .pc_o(pc_o),
        .bar_wen_o(bar_wen_o), .bar_mask_o(bar_mask_o), .drop_count_o(drop_count_o),
        .op_err_o(op_err_o), .fifo_count_o(fifo_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [13:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors;
    int   checks;
    int   model_drops;
    bit   model_err;
    bit   mon_en;
    bit   rand_ready;
    int   cyc;
    int   mon_n;
    int   got_op;
    int   reg_cnt;
    int   reg_first;
    int   reg_last;

    function automatic logic [PKT_W-1:0] mk(input logic [9:0] id, input logic [2:0] op,
                                             input logic [13:0] addr, input logic [31:0] data);
        logic [5:0] rsv;
        rsv = 6'($urandom);
        return {id, op, rsv, addr, data};
    endfunction

    // Reference model of the accept-side filter.
    task automatic model_accept(input logic [PKT_W-1:0] p);
        logic [9:0] id;
        exp_t       e;
        id     = p[PKT_W-1 -: 10];
        e.op   = p[PKT_W-11 -: 3];
        e.addr = p[45:32];
        e.data = p[31:0];
        if (id == 10'd0 || id == 10'h3FF) begin
            if (e.op >= 3'd1 && e.op <= 3'd4) exp_q.push_back(e);
            else if (e.op >= 3'd5) model_err = 1'b1;
        end else if (model_drops < 255) begin
            model_drops++;
        end
    endtask

    // Dispatch monitor: every strobe cycle must match the head of the model queue.
    always @(negedge clk) begin
        cyc++;
        if (n_reset && mon_en) begin
            mon_n = 0;
            if (imem_wen_o) mon_n++;
            if (reg_wen_o)  mon_n++;
            if (pc_wen_o)   mon_n++;
            if (bar_wen_o)  mon_n++;
            if (mon_n > 0) begin
                checks++;
                if (mon_n != 1) begin
                    errors++;
                    $display("FAIL one_hot_strobe got=%0d required=1 @cyc %0d", mon_n, cyc);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_dispatch imem=%b reg=%b pc=%b bar=%b required none",
                             imem_wen_o, reg_wen_o, pc_wen_o, bar_wen_o);
                end else begin
                    mon_e  = exp_q[0];
                    got_op = imem_wen_o ? 1 : reg_wen_o ? 2 : pc_wen_o ? 3 : 4;
                    if (got_op != int'(mon_e.op)) begin
                        errors++;
                        $display("FAIL dispatch_op got=%0d required=%0d", got_op, mon_e.op);
                    end else if (got_op == 1 && (imem_addr_o !== mon_e.addr[9:0] ||
                                                 imem_data_o !== mon_e.data[15:0])) begin
                        errors++;
                        $display("FAIL imem_fields got=%h/%h required=%h/%h", imem_addr_o,
                                 imem_data_o, mon_e.addr[9:0], mon_e.data[15:0]);
                    end else if (got_op == 2 && (reg_addr_o !== mon_e.addr[4:0] ||
                                                 reg_data_o !== mon_e.data)) begin
                        errors++;
                        $display("FAIL reg_fields got=%h/%h required=%h/%h", reg_addr_o,
                                 reg_data_o, mon_e.addr[4:0], mon_e.data);
                    end else if (got_op == 3 && pc_o !== mon_e.data[9:0]) begin
                        errors++;
                        $display("FAIL pc_field got=%h required=%h", pc_o, mon_e.data[9:0]);
                    end else if (got_op == 4 && bar_mask_o !== mon_e.data[2:0]) begin
                        errors++;
                        $display("FAIL bar_field got=%b required=%b", bar_mask_o, mon_e.data[2:0]);
                    end
                    if (got_op != 1 || imem_ready_i) void'(exp_q.pop_front());
                end
                if (reg_wen_o) begin
                    reg_cnt++;
                    if (reg_cnt == 1) reg_first = cyc;
                    reg_last = cyc;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 imem_ready_i = 1'($urandom);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Must be called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic push(input logic [PKT_W-1:0] p);
        bit got;
        got         = 1'b0;
        pkt_i       = p;
        pkt_valid_i = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (pkt_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL push_timeout ready=%b required=1", pkt_ready_o);
        end else begin
            model_accept(p);
        end
        @(posedge clk);
        #1;
        pkt_valid_i = 1'b0;
    endtask

    task automatic wait_strobe(input string name, input int which);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if ((which == 1 && imem_wen_o) || (which == 3 && pc_wen_o) ||
                (which == 4 && bar_wen_o)) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout strobe=0 required=1", name);
        end
    endtask

    task automatic drain();
        bit idle;
        imem_ready_i = 1'b1;
        idle         = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (fifo_count_o == 3'd0 && exp_q.size() == 0 &&
                !(imem_wen_o || reg_wen_o || pc_wen_o || bar_wen_o)) begin
                idle = 1'b1;
                break;
            end
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL drain_timeout count=%0d pending=%0d required=0/0",
                     fifo_count_o, exp_q.size());
        end
        tick();
    endtask

    task automatic apply_reset();
        n_reset = 1'b0;
        exp_q.delete();
        model_drops = 0;
        model_err   = 1'b0;
        #23;
        @(negedge clk);
        n_reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (pkt_ready_o !== 1'b1 || fifo_count_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_fifo ready=%b count=%0d required=1/0", pkt_ready_o, fifo_count_o);
        end
        checks++;
        if ({imem_wen_o, reg_wen_o, pc_wen_o, bar_wen_o} !== 4'b0) begin
            errors++;
            $display("FAIL reset_strobes got=%b required=0000",
                     {imem_wen_o, reg_wen_o, pc_wen_o, bar_wen_o});
        end
        checks++;
        if (drop_count_o !== 8'd0 || op_err_o !== 1'b0 || reg_data_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_status drop=%0d err=%b data=%h required=0/0/0",
                     drop_count_o, op_err_o, reg_data_o);
        end
        tick();
    endtask

    task automatic test_reg_latency();
        imem_ready_i = 1'b1;
        push(mk(10'd0, 3'd2, 14'd3, 32'hDEADBEEF));
        @(negedge clk);
        checks++;
        if (reg_wen_o !== 1'b0) begin
            errors++;
            $display("FAIL latency_cycle1 reg_wen=%b required=0", reg_wen_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (reg_wen_o !== 1'b1 || reg_addr_o !== 5'd3 || reg_data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL latency_cycle2 wen=%b addr=%0d data=%h required=1/3/deadbeef",
                     reg_wen_o, reg_addr_o, reg_data_o);
        end
        @(negedge clk);
        checks++;
        if (reg_wen_o !== 1'b0 || fifo_count_o !== 3'd0) begin
            errors++;
            $display("FAIL reg_one_cycle wen=%b count=%0d required=0/0", reg_wen_o, fifo_count_o);
        end
        tick();
    endtask

    task automatic test_instr_stall();
        int held;
        imem_ready_i = 1'b0;
        push(mk(10'h3FF, 3'd1, 14'h12, 32'h0ABC));
        wait_strobe("instr", 1);
        held = (imem_addr_o == 10'h12 && imem_data_o == 16'h0ABC) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            if (imem_wen_o && imem_addr_o == 10'h12 && imem_data_o == 16'h0ABC) held++;
        end
        tick();
        imem_ready_i = 1'b1;
        @(negedge clk);
        if (imem_wen_o && imem_addr_o == 10'h12 && imem_data_o == 16'h0ABC) held++;
        tick();
        imem_ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (held != 6 || imem_wen_o !== 1'b0) begin
            errors++;
            $display("FAIL instr_hold held=%0d wen_after=%b required=6/0", held, imem_wen_o);
        end
        tick();
    endtask

    task automatic test_backpressure();
        imem_ready_i = 1'b0;
        push(mk(10'd0, 3'd1, 14'($urandom), $urandom));
        wait_strobe("bp_instr", 1);
        tick();
        for (int i = 0; i < 4; i++) push(mk(10'd0, 3'd2, 14'(i + 1), 32'(100 + i)));
        @(negedge clk);
        checks++;
        if (pkt_ready_o !== 1'b0 || fifo_count_o !== 3'd4) begin
            errors++;
            $display("FAIL full_ready ready=%b count=%0d required=0/4", pkt_ready_o, fifo_count_o);
        end
        tick();
        reg_cnt      = 0;
        imem_ready_i = 1'b1;
        push(mk(10'd0, 3'd2, 14'd5, 32'd104));
        drain();
        checks++;
        if (reg_cnt != 5 || reg_last - reg_first != 4) begin
            errors++;
            $display("FAIL reg_stream count=%0d span=%0d required=5/4", reg_cnt,
                     reg_last - reg_first);
        end
    endtask

    task automatic test_drop_saturate();
        imem_ready_i = 1'b1;
        for (int i = 0; i < 300; i++) push(mk(10'd5, 3'($urandom), 14'($urandom), $urandom));
        @(negedge clk);
        checks++;
        if (drop_count_o !== 8'(model_drops) || model_drops != 255) begin
            errors++;
            $display("FAIL drop_saturate got=%0d required=%0d", drop_count_o, model_drops);
        end
        tick();
        push(mk(10'd0, 3'd4, 14'($urandom), 32'h5));
        wait_strobe("bar", 4);
        checks++;
        if (bar_mask_o !== 3'b101) begin
            errors++;
            $display("FAIL bar_mask got=%b required=101", bar_mask_o);
        end
        tick();
        drain();
    endtask

    task automatic test_op_err();
        push(mk(10'd0, 3'd6, 14'($urandom), $urandom));
        drain();
        checks++;
        if (op_err_o !== 1'b1) begin
            errors++;
            $display("FAIL op_err_set got=%b required=1", op_err_o);
        end
        push(mk(10'd0, 3'd3, 14'($urandom), 32'h2A));
        wait_strobe("pc", 3);
        checks++;
        if (pc_o !== 10'h2A) begin
            errors++;
            $display("FAIL pc_value got=%h required=02a", pc_o);
        end
        tick();
        drain();
        checks++;
        if (op_err_o !== 1'b1) begin
            errors++;
            $display("FAIL op_err_sticky got=%b required=1", op_err_o);
        end
    endtask

    task automatic test_random();
        logic [9:0] id;
        int         r;
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            r  = $urandom_range(0, 3);
            id = (r == 0) ? 10'd0 : (r == 1) ? 10'h3FF : 10'($urandom);
            push(mk(id, 3'($urandom), 14'($urandom), $urandom));
        end
        rand_ready = 1'b0;
        tick();
        drain();
        checks++;
        if (drop_count_o !== 8'(model_drops) || op_err_o !== model_err) begin
            errors++;
            $display("FAIL random_status drop=%0d err=%b required=%0d/%b", drop_count_o,
                     op_err_o, model_drops, model_err);
        end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        imem_ready_i = 1'b0;
        push(mk(10'd0, 3'd1, 14'($urandom), $urandom));
        wait_strobe("rst_instr", 1);
        tick();
        for (int i = 0; i < 3; i++) push(mk(10'd0, 3'd2, 14'($urandom), $urandom));
        @(negedge clk);
        checks++;
        if (fifo_count_o !== 3'd3 || imem_wen_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset count=%0d wen=%b required=3/1", fifo_count_o, imem_wen_o);
        end
        #2;
        n_reset = 1'b0;
        exp_q.delete();
        model_drops = 0;
        model_err   = 1'b0;
        #1;
        checks++;
        if ({imem_wen_o, reg_wen_o, pc_wen_o, bar_wen_o} !== 4'b0 || imem_addr_o !== 10'd0) begin
            errors++;
            $display("FAIL async_reset_strobes got=%b addr=%h required=0000/000",
                     {imem_wen_o, reg_wen_o, pc_wen_o, bar_wen_o}, imem_addr_o);
        end
        @(negedge clk);
        n_reset      = 1'b1;
        imem_ready_i = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (fifo_count_o !== 3'd0 || pkt_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL post_reset count=%0d ready=%b required=0/1", fifo_count_o, pkt_ready_o);
        end
        tick();
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        cyc          = 0;
        reg_cnt      = 0;
        reg_first    = 0;
        reg_last     = 0;
        model_drops  = 0;
        model_err    = 1'b0;
        rand_ready   = 1'b0;
        mon_en       = 1'b1;
        n_reset      = 1'b0;
        pkt_valid_i  = 1'b0;
        pkt_i        = '0;
        imem_ready_i = 1'b1;
        test_reset();
        test_reg_latency();
        test_instr_stall();
        test_backpressure();
        test_drop_saturate();
        test_op_err();
        test_random();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached, required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/net_packet_dispatcher.md
Name: net_packet_dispatcher

Overview:
Parametrised network-packet front end for the core. It accepts network packets, filters them by destination ID, and buffers accepted packets in a FIFO of configurable depth. It decodes each packet's net_op and dispatches it to the instruction-memory, register-file, PC or barrier-mask write ports. It generalises the fixed 10-bit ID / 3-bit mask / single-slot packet handling to parametric widths, adds broadcast, buffering and backpressure, and adds drop and error accounting.

Parameters:
ID_WIDTH, 10, destination ID field width
ADDR_WIDTH, 14, net_addr field width
DATA_WIDTH, 32, net_data field width
FIFO_DEPTH, 4, packet buffer entries (power of 2, >=2)
MY_ID, 0, this core's ID
IMEM_ADDR_WIDTH, 10, instruction memory address width
RD_SIZE, 5, register index width
MASK_WIDTH, 3, barrier mask width

Ports:
clk  in  1  clock
n_reset  in  1  asynchronous active-low reset
pkt_valid_i  in  1  packet offered
pkt_i  in  ID_WIDTH+3+6+ADDR_WIDTH+DATA_WIDTH  packet, fields MSB->LSB: ID, net_op, reserved, net_addr, net_data
pkt_ready_o  out  1  packet accepted when valid&ready
imem_wen_o  out  1  instruction write request (valid)
imem_ready_i  in  1  imem accepts write this cycle
imem_addr_o  out  IMEM_ADDR_WIDTH  net_addr[IMEM_ADDR_WIDTH-1:0]
imem_data_o  out  16  net_data[15:0]
reg_wen_o  out  1  register write strobe
reg_addr_o  out  RD_SIZE  net_addr[RD_SIZE-1:0]
reg_data_o  out  DATA_WIDTH  net_data
pc_wen_o  out  1  PC load strobe
pc_o  out  IMEM_ADDR_WIDTH  net_data[IMEM_ADDR_WIDTH-1:0]
bar_wen_o  out  1  barrier mask load strobe
bar_mask_o  out  MASK_WIDTH  net_data[MASK_WIDTH-1:0]
drop_count_o  out  8  saturating count of ID-filtered packets
op_err_o  out  1  sticky: unknown net_op seen
fifo_count_o  out  $clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Reset (async, n_reset=0): FIFO flushed, all strobes 0, all data outputs 0, drop_count_o=0, op_err_o=0, FSM=D_IDLE. Any in-flight or pending packet is discarded; strobes drop immediately, not at the next edge.
- pkt_ready_o = (fifo_count_o != FIFO_DEPTH); combinational from occupancy only. There is no full-bypass: when full, ready is 0 even if a dequeue happens this cycle.
- Filter on accept: ID==MY_ID or ID==all-ones (broadcast) -> enqueue if op is INSTR(001)/REG(010)/PC(011)/BAR(100).
  - Matching NULL(000): discarded, not counted.
  - Matching op 101..111: discarded, op_err_o set (sticky until reset).
  - Non-matching ID: discarded, drop_count_o +1, saturating at 255.
  - Discarded packets still complete the handshake; ready is unaffected.
- Dispatch register holds one decoded packet. FSM states:
  - D_IDLE: register empty. If the FIFO is non-empty, pop the head and load the register -> D_ISSUE.
  - D_ISSUE: the strobe for the loaded op is high.
    - REG/PC/BAR: strobe lasts exactly one cycle. Next state is D_ISSUE with the next popped head if the FIFO is non-empty, else D_IDLE (back-to-back, 1 packet/cycle).
    - INSTR: imem_wen_o and address/data are held stable until a cycle with imem_ready_i=1. That cycle completes the transfer; advance as above.
- Exactly one of the four strobes is high in D_ISSUE; none are high in D_IDLE.
- Latency: packet accepted in cycle 0 (empty FIFO, D_IDLE) -> strobe high in cycle 2.
- Ordering: strictly FIFO. Packets are never reordered or merged.
- Occupancy: simultaneous push and pop leaves fifo_count_o unchanged. Read/write pointers wrap modulo FIFO_DEPTH.
- Field extraction truncates to the low bits. Upper address/data bits are ignored without error.

Test Plan:
- Reset then send {ID=0, REG, addr=3, data=0xDEADBEEF} with imem_ready_i=1 -> cycle 2: reg_wen_o=1, reg_addr_o=3, reg_data_o=0xDEADBEEF for one cycle; fifo_count_o returns to 0.
- INSTR {ID=0x3FF, addr=0x12, data=0x0ABC} with imem_ready_i low for 5 cycles, then high -> imem_wen_o held with addr 0x12 and data 0x0ABC for 6 cycles; deasserts after the ready cycle.
- Hold imem_ready_i=0 with an INSTR at issue and push 5 REG packets (FIFO_DEPTH=4) -> pkt_ready_o falls after the 4th accept. Release ready -> REGs dispatch in order on consecutive cycles.
- 300 packets with ID=5 -> none dispatched; drop_count_o=255. One BAR {ID=0, data=0x5} -> bar_wen_o pulse, bar_mask_o=3'b101.
- Packet with op=110, ID=0 -> no strobe, op_err_o=1 persisting. A subsequent PC packet with data=0x2A -> pc_wen_o pulse, pc_o=0x2A.
- Assert n_reset=0 mid-INSTR-stall with 3 queued -> strobes 0 immediately; after release fifo_count_o=0 and no stale dispatch.
